// File: rtl/capp_search_ctrl.sv
// rtl/capp_search_ctrl.sv - search sequencer for the CAPP compare datapath
//
// Accepts one search request (comparand + mask), holds perform_search high
// for SETTLE_CYCLES cycles, captures the cell array's match vector on the
// last of those cycles and returns it with a lowest-index first responder.
//
// Ports:
//   CLK, RST_N       clock (rising edge), asynchronous active-low reset
//   req_valid/ready  request handshake; req_comparand, req_mask carry the search
//   cmp_comparand    comparand driven to the compare array (held between accepts)
//   cmp_mask         mask driven to the compare array (1 = bit compared)
//   perform_search   high for exactly SETTLE_CYCLES cycles per search
//   cell_match       per-cell match lines, sampled only in the capture cycle
//   rsp_valid/ready  response handshake; rsp_tags, rsp_any, rsp_index carry it
//   busy             high while searching or presenting a response
//   rsp_count        population count of rsp_tags (CAPP_MATCH_COUNT_EN only)
//
// Build option: define CAPP_MATCH_COUNT_EN to add the rsp_count output.

module capp_search_ctrl #(
  parameter int NUM_BITS      = 32,
  parameter int NUM_CELLS     = 100,
  parameter int SETTLE_CYCLES = 2,
  parameter int IDX_W         = $clog2(NUM_CELLS)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [NUM_BITS-1:0]  req_comparand,
  input  logic [NUM_BITS-1:0]  req_mask,
  output logic [NUM_BITS-1:0]  cmp_comparand,
  output logic [NUM_BITS-1:0]  cmp_mask,
  output logic                 perform_search,
  input  logic [NUM_CELLS-1:0] cell_match,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [NUM_CELLS-1:0] rsp_tags,
  output logic                 rsp_any,
  output logic [IDX_W-1:0]     rsp_index,
  output logic                 busy
`ifdef CAPP_MATCH_COUNT_EN
  ,
  output logic [$clog2(NUM_CELLS+1)-1:0] rsp_count
`endif
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  generate
    if (SETTLE_CYCLES < 1) begin : g_settle_check
      $error("capp_search_ctrl: SETTLE_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             init_q;
  logic             accept;
  logic             capture;

  // req_ready must stay low until the first edge after reset release, so the
  // IDLE state alone is not enough to advertise readiness.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      init_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    perform_search = 1'b0;
    rsp_valid      = 1'b0;
    busy           = 1'b0;
    accept         = 1'b0;
    capture        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = init_q;
        if (req_valid && init_q) begin
          accept  = 1'b1;
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        perform_search = 1'b1;
        busy           = 1'b1;
        // The last settle cycle is also the capture cycle.
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        rsp_valid = 1'b1;
        busy      = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Settle counter: loaded on accept, counts down through SEARCH.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= CNT_W'(SETTLE_CYCLES - 1);
    end else if (state_q == ST_SEARCH && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Comparand/mask change only on an accept edge, never during SEARCH.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cmp_comparand <= '0;
      cmp_mask      <= '0;
    end else if (accept) begin
      cmp_comparand <= req_comparand;
      cmp_mask      <= req_mask;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rsp_tags <= '0;
    end else if (capture) begin
      rsp_tags <= cell_match;
    end
  end

  // First responder is derived from the registered tags so it cannot move
  // while a response is being held.
  always_comb begin
    rsp_index = '0;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (rsp_tags[i]) begin
        rsp_index = IDX_W'(i);
      end
    end
  end

  assign rsp_any = |rsp_tags;

`ifdef CAPP_MATCH_COUNT_EN
  localparam int POP_W = $clog2(NUM_CELLS + 1);

  logic [POP_W-1:0] match_pop;

  always_comb begin
    match_pop = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      match_pop = match_pop + POP_W'(cell_match[i]);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rsp_count <= '0;
    end else if (capture) begin
      rsp_count <= match_pop;
    end
  end
`endif

endmodule

// File: tb/tb_capp_search_ctrl.sv
// tb/tb_capp_search_ctrl.sv - self-checking bench for capp_search_ctrl

module tb_capp_search_ctrl;

  localparam int NB     = 32;
  localparam int NC     = 100;
  localparam int SETTLE = 2;
  localparam int IW     = 7;

  logic          CLK;
  logic          RST_N;
  logic          req_valid;
  logic          req_ready;
  logic [NB-1:0] req_comparand;
  logic [NB-1:0] req_mask;
  logic [NB-1:0] cmp_comparand;
  logic [NB-1:0] cmp_mask;
  logic          perform_search;
  logic [NC-1:0] cell_match;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [NC-1:0] rsp_tags;
  logic          rsp_any;
  logic [IW-1:0] rsp_index;
  logic          busy;
`ifdef CAPP_MATCH_COUNT_EN
  logic [6:0]    rsp_count;
`endif

  capp_search_ctrl #(
    .NUM_BITS(NB), .NUM_CELLS(NC), .SETTLE_CYCLES(SETTLE), .IDX_W(IW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_comparand(req_comparand), .req_mask(req_mask),
    .cmp_comparand(cmp_comparand), .cmp_mask(cmp_mask),
    .perform_search(perform_search), .cell_match(cell_match),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_tags(rsp_tags), .rsp_any(rsp_any), .rsp_index(rsp_index),
    .busy(busy)
`ifdef CAPP_MATCH_COUNT_EN
    , .rsp_count(rsp_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [NB-1:0] comparand;
    logic [NB-1:0] mask;
    logic [NC-1:0] match;
    logic          exp_any;
    logic [IW-1:0] exp_index;
    logic [6:0]    exp_count;
    int            hold;
  } vec_t;

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_search(input vec_t v);
    int t;
    int ps;
    t = 0;
    while (!req_ready && t < 10) begin
      tick();
      t++;
    end
    chk("ready_before_req", 128'(req_ready), 128'(1));
    req_comparand = v.comparand;
    req_mask      = v.mask;
    req_valid     = 1'b1;
    cell_match    = ~v.match;
    tick();
    req_valid = 1'b0;
    chk("cmp_comparand", 128'(cmp_comparand), 128'(v.comparand));
    chk("cmp_mask", 128'(cmp_mask), 128'(v.mask));
    chk("busy_search", 128'(busy), 128'(1));
    // Only the value present in the final settle cycle may be captured.
    ps = 0;
    while (perform_search && ps < 20) begin
      ps++;
      cell_match = (ps == SETTLE) ? v.match : ~v.match;
      tick();
    end
    cell_match = ~v.match;
    chk("search_cycles", 128'(ps), 128'(SETTLE));
    chk("rsp_valid", 128'(rsp_valid), 128'(1));
    chk("rsp_tags", 128'(rsp_tags), 128'(v.match));
    chk("rsp_any", 128'(rsp_any), 128'(v.exp_any));
    chk("rsp_index", 128'(rsp_index), 128'(v.exp_index));
`ifdef CAPP_MATCH_COUNT_EN
    chk("rsp_count", 128'(rsp_count), 128'(v.exp_count));
`endif
    for (int k = 0; k < v.hold; k++) begin
      req_valid     = 1'b1;
      req_comparand = ~v.comparand;
      tick();
      chk("hold_rsp_valid", 128'(rsp_valid), 128'(1));
      chk("hold_req_ready", 128'(req_ready), 128'(0));
      chk("hold_perform", 128'(perform_search), 128'(0));
      chk("hold_tags", 128'(rsp_tags), 128'(v.match));
      chk("hold_index", 128'(rsp_index), 128'(v.exp_index));
      chk("hold_cmp", 128'(cmp_comparand), 128'(v.comparand));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("done_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("done_req_ready", 128'(req_ready), 128'(1));
    chk("done_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    int acc[$];
    logic hs;

    vecs[0] = '{32'hA5, 32'hFF, (100'd1 << 3) | (100'd1 << 7) | (100'd1 << 42),
                1'b1, 7'd3, 7'd3, 0};
    vecs[1] = '{32'h1234_5678, 32'hFFFF_FFFF, 100'd0, 1'b0, 7'd0, 7'd0, 0};
    vecs[2] = '{32'h0, 32'hFFFF_0000, {100{1'b1}}, 1'b1, 7'd0, 7'd100, 0};
    vecs[3] = '{32'h8000_0001, 32'h0000_FFFF, 100'd1 << 99, 1'b1, 7'd99, 7'd1, 0};
    vecs[4] = '{32'hDEAD_BEEF, 32'h0, (100'd1 << 50) | (100'd1 << 51),
                1'b1, 7'd50, 7'd2, 0};
    vecs[5] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, (100'd1 << 99) | 100'd1,
                1'b1, 7'd0, 7'd2, 5};

    RST_N         = 1'b0;
    req_valid     = 1'b0;
    req_comparand = '0;
    req_mask      = '0;
    cell_match    = '0;
    rsp_ready     = 1'b0;

    #12;
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_perform", 128'(perform_search), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_tags", 128'(rsp_tags), 128'(0));
    chk("rst_cmp", 128'(cmp_comparand), 128'(0));
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("rel_req_ready_low", 128'(req_ready), 128'(0));
    tick();
    chk("rel_req_ready_high", 128'(req_ready), 128'(1));

    for (int i = 0; i < 6; i++) do_search(vecs[i]);

    // Reset during the second SEARCH cycle aborts the search.
    req_comparand = 32'hCAFE_F00D;
    req_mask      = 32'hFFFF_FFFF;
    cell_match    = {100{1'b1}};
    req_valid     = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("abort_in_search", 128'(perform_search), 128'(1));
    RST_N = 1'b0;
    #1;
    chk("abort_perform", 128'(perform_search), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_req_ready", 128'(req_ready), 128'(0));
    chk("abort_cmp", 128'(cmp_comparand), 128'(0));
    chk("abort_mask", 128'(cmp_mask), 128'(0));
    chk("abort_tags", 128'(rsp_tags), 128'(0));
    tick();
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("abort_rel_ready_low", 128'(req_ready), 128'(0));
    tick();
    chk("abort_rel_ready_high", 128'(req_ready), 128'(1));
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_no_rsp", 128'(rsp_valid), 128'(0));
    end

    // Back-to-back requests with the consumer always ready.
    cell_match    = '0;
    rsp_ready     = 1'b1;
    req_valid     = 1'b1;
    req_comparand = 32'h1000_0000;
    for (int cyc = 0; cyc < 16; cyc++) begin
      hs = req_ready && req_valid;
      tick();
      if (hs) begin
        acc.push_back(cyc);
        chk("b2b_cmp_accept", 128'(cmp_comparand), 128'(req_comparand));
        req_comparand = req_comparand + 32'd1;
      end else begin
        chk("b2b_cmp_hold", 128'(cmp_comparand), 128'(req_comparand - 32'd1));
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 128'(acc.size()), 128'(4));
    for (int k = 0; k < acc.size(); k++) begin
      chk("b2b_spacing", 128'(acc[k]), 128'(4 * k));
    end
    for (int k = 0; k < 6; k++) tick();
    rsp_ready = 1'b0;
    chk("b2b_idle", 128'(busy), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
